// File: rtl/bus6502_timer_irq_if.sv
// CPU-side bus bundle for the 6502 timer/interrupt responder.
interface bus6502_timer_irq_if;
    logic [15:0] address;
    logic        read_not_write;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        selected;

    modport master (
        output address, read_not_write, write_data,
        input  read_data, selected
    );

    modport slave (
        input  address, read_not_write, write_data,
        output read_data, selected
    );
endinterface

// File: rtl/bus6502_timer_irq.sv
// Memory-mapped interval timer with IRQ/NMI output on the cpu6502 bus (SRAM phase).
// Optional BUS6502_TIMER_IRQ_COUNT_LATCH_EN: COUNT_LO read snapshots COUNT_HI for coherent 16-bit reads.
module bus6502_timer_irq #(
    parameter logic [15:0] BASE_ADDRESS   = 16'hFE00,
    parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
    input  logic                      clk,
    input  logic                      clk__enable,
    input  logic                      reset,
    bus6502_timer_irq_if.slave        bus,
    output logic                      irq_n,
    output logic                      nmi_n
);

    // ctrl bits: 0 RUN, 1 IRQ_EN, 2 AUTO_RELOAD, 3 NMI_SEL
    logic [3:0]  ctrl_q,      ctrl_d;
    logic        expired_q,   expired_d;
    logic [15:0] reload_q,    reload_d;
    logic [15:0] count_q,     count_d;
    logic [7:0]  prescale_q,  prescale_d;
    logic [7:0]  scratch_q,   scratch_d;
    logic [7:0]  presc_q,     presc_d;
    logic [7:0]  read_data_q, read_data_d;
    logic        selected_q,  selected_d;
    logic        irq_n_q,     irq_n_d;
    logic        nmi_n_q,     nmi_n_d;
`ifdef BUS6502_TIMER_IRQ_COUNT_LATCH_EN
    logic [7:0]  snap_q,      snap_d;
`endif

    logic       hit, rd_hit, wr_hit, ctrl_wr, hi_wr, tick;
    logic [2:0] off;
    logic [7:0] rd_val;

    assign hit     = (bus.address[15:3] == BASE_ADDRESS[15:3]);
    assign off     = bus.address[2:0];
    assign rd_hit  = hit &  bus.read_not_write;
    assign wr_hit  = hit & ~bus.read_not_write;
    assign ctrl_wr = wr_hit && (off == 3'd0);
    assign hi_wr   = wr_hit && (off == 3'd3);
    assign tick    = ctrl_q[0] && (presc_q == 8'h00);

    always_comb begin
        rd_val = '0;
        case (off)
            3'd0: rd_val = {4'b0000, ctrl_q};
            3'd1: rd_val = {7'b0000000, expired_q};
            3'd2: rd_val = reload_q[7:0];
            3'd3: rd_val = reload_q[15:8];
            3'd4: rd_val = count_q[7:0];
`ifdef BUS6502_TIMER_IRQ_COUNT_LATCH_EN
            3'd5: rd_val = snap_q;
`else
            3'd5: rd_val = count_q[15:8];
`endif
            3'd6: rd_val = prescale_q;
            3'd7: rd_val = scratch_q;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        expired_d  = expired_q;
        reload_d   = reload_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        scratch_d  = scratch_q;
        presc_d    = presc_q;

        if (wr_hit) begin
            case (off)
                3'd0: ctrl_d = bus.write_data[3:0];
                3'd1: if (bus.write_data[0]) expired_d = 1'b0;
                3'd2: reload_d[7:0] = bus.write_data;
                3'd3: reload_d[15:8] = bus.write_data;
                3'd6: prescale_d = bus.write_data;
                3'd7: scratch_d = bus.write_data;
                default: ;
            endcase
        end

        if (!ctrl_q[0]) begin
            presc_d = prescale_d;
        end else if (presc_q == 8'h00) begin
            presc_d = prescale_q;
        end else begin
            presc_d = presc_q - 8'd1;
        end

        // Expiry is applied after the STATUS clear so a coincident set wins;
        // a CTRL write keeps its RUN value over the expiry stop.
        if (hi_wr) begin
            count_d = {bus.write_data, reload_q[7:0]};
        end else if (tick) begin
            if (count_q != 16'h0000) begin
                count_d = count_q - 16'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[2]) begin
                    count_d = reload_q;
                end else if (!ctrl_wr) begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        irq_n_d = !(expired_d & ctrl_d[1] & !ctrl_d[3]);
        nmi_n_d = !(expired_d & ctrl_d[1] &  ctrl_d[3]);
    end

    always_comb begin
        read_data_d = rd_hit ? rd_val : read_data_q;
        selected_d  = hit;
`ifdef BUS6502_TIMER_IRQ_COUNT_LATCH_EN
        snap_d = (rd_hit && (off == 3'd4)) ? count_q[15:8] : snap_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            expired_q   <= 1'b0;
            reload_q    <= '0;
            count_q     <= '0;
            prescale_q  <= RESET_PRESCALE;
            scratch_q   <= '0;
            presc_q     <= RESET_PRESCALE;
            read_data_q <= '0;
            selected_q  <= 1'b0;
            irq_n_q     <= 1'b1;
            nmi_n_q     <= 1'b1;
`ifdef BUS6502_TIMER_IRQ_COUNT_LATCH_EN
            snap_q      <= '0;
`endif
        end else if (clk__enable) begin
            ctrl_q      <= ctrl_d;
            expired_q   <= expired_d;
            reload_q    <= reload_d;
            count_q     <= count_d;
            prescale_q  <= prescale_d;
            scratch_q   <= scratch_d;
            presc_q     <= presc_d;
            read_data_q <= read_data_d;
            selected_q  <= selected_d;
            irq_n_q     <= irq_n_d;
            nmi_n_q     <= nmi_n_d;
`ifdef BUS6502_TIMER_IRQ_COUNT_LATCH_EN
            snap_q      <= snap_d;
`endif
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.selected  = selected_q;
    assign irq_n         = irq_n_q;
    assign nmi_n         = nmi_n_q;

endmodule

// File: doc/bus6502_timer_irq.md
Name: bus6502_timer_irq

Overview:
- Memory-mapped interval timer and interrupt source. Sits as a responder on the cpu6502 bus (address / read_not_write / write data / read data), in parallel with the system SRAM.
- Drives the CPU's irq_n and nmi_n inputs, which are otherwise tied inactive.
- Sampled on the SRAM phase of the CPU/SRAM ping-pong. Read data is registered and returned to the CPU on its next enabled edge, exactly like the SRAM.

Parameters:
- BASE_ADDRESS, 16'hFE00, base of the 8-byte register window; bits [2:0] are ignored.
- RESET_PRESCALE, 8'h00, reset value of the PRESCALE register.

Ports:
- clk  input  1  system clock.
- clk__enable  input  1  clock enable; connected to the SRAM-phase enable, so all state advances only when high.
- reset  input  1  synchronous, active-high reset.
- address  input  16  CPU bus address.
- read_not_write  input  1  CPU bus direction; 1 = read.
- write_data  input  8  CPU write data.
- read_data  output  8  registered read data.
- selected  output  1  registered; high when the last sampled access hit the window. Used by the system read mux against SRAM data.
- irq_n  output  1  active-low maskable interrupt.
- nmi_n  output  1  active-low non-maskable interrupt.

Behaviour:
- Only clk__enable edges are significant. "Cycle" below means one enabled edge.
- Access decode: hit = (address[15:3] == BASE_ADDRESS[15:3]). Every enabled cycle is treated as a bus access.
- Register map (offset address[2:0]):
  - 0 CTRL, R/W: bit0 RUN, bit1 IRQ_EN, bit2 AUTO_RELOAD, bit3 NMI_SEL; bits 7:4 read 0.
  - 1 STATUS: bit0 EXPIRED. Write 1 to clear; write 0 has no effect. Other bits read 0.
  - 2 RELOAD_LO, R/W.
  - 3 RELOAD_HI, R/W. Writing it also loads COUNT <= {write_data, RELOAD_LO}.
  - 4 COUNT_LO, R.
  - 5 COUNT_HI, R. Writes to offsets 4 and 5 are ignored.
  - 6 PRESCALE, R/W.
  - 7 SCRATCH, R/W.
- Read on hit: read_data <= register value and selected <= 1, one cycle latency. Registers are unaffected, except where the optional feature applies.
- Miss: selected <= 0; read_data holds.
- Write on hit: selected <= 1; read_data holds.
- Prescaler (8-bit):
  - Counts down only while RUN = 1.
  - At 0 it asserts tick and reloads from PRESCALE, so ticks occur every PRESCALE+1 cycles.
  - When RUN = 0 the prescaler is held at PRESCALE.
- Counter (16-bit COUNT), on tick:
  - If COUNT != 0: COUNT <= COUNT - 1.
  - If COUNT == 0: EXPIRED <= 1. If AUTO_RELOAD = 1, COUNT <= RELOAD; otherwise COUNT stays 0 and RUN <= 0. No wrap to FFFF.
- Interrupt outputs are registered from next-state flags:
  - irq_n = !(EXPIRED & IRQ_EN & !NMI_SEL).
  - nmi_n = !(EXPIRED & IRQ_EN & NMI_SEL).
  - Both update one cycle after the cause.
- Simultaneous events:
  - Expiry set and a STATUS clear in the same cycle: set wins.
  - CTRL write and tick in the same cycle: the write value of RUN wins, but the tick's decrement/expiry still occurs.
  - RELOAD_HI write and tick in the same cycle: the write load wins and the tick is discarded.
- Reset (any time, including mid-count or mid-access):
  - CTRL, STATUS, COUNT, RELOAD, SCRATCH = 0; PRESCALE = RESET_PRESCALE; prescaler = RESET_PRESCALE.
  - read_data = 8'h00, selected = 0, irq_n = 1, nmi_n = 1.
  - Reset overrides clk__enable.

Optional Feature:
- Macro: BUS6502_TIMER_IRQ_COUNT_LATCH_EN.
- With the macro: a read of COUNT_LO captures COUNT[15:8] into a snapshot register, and a subsequent COUNT_HI read returns the snapshot. The snapshot resets to 0. This gives a coherent 16-bit read across decrements.
- Without the macro: COUNT_HI returns live COUNT[15:8], and there is no snapshot register.

Test Plan:
- Reset then read offsets 0–7 at FE00–FE07 → read_data 00, except offset 6 = RESET_PRESCALE; irq_n = nmi_n = 1; selected = 1 one cycle after each read.
- Write RELOAD_LO=03, RELOAD_HI=00, PRESCALE=00, CTRL=03 → COUNT reads 3, 2, 1, 0 on successive ticks. EXPIRED = 1 on the tick at 0, irq_n = 0 next cycle, RUN clears. Writing STATUS=01 → irq_n = 1 next cycle.
- CTRL=0F (AUTO_RELOAD, NMI_SEL), RELOAD=0002, PRESCALE=01 → expiry every 6 cycles; nmi_n low and irq_n stays high; COUNT reloads to 2, not FFFF.
- STATUS clear written on the same cycle as an expiry → EXPIRED remains 1 and irq_n stays 0.
- Reset asserted mid-count (COUNT=1234, RUN=1) → all state returns to reset values on that edge; no tick afterwards.
- With BUS6502_TIMER_IRQ_COUNT_LATCH_EN and COUNT=0100 decrementing across the boundary: read LO (00) then HI → 01; without the macro the HI read returns 00.
